// File: rtl/stopwatch_controller_if.sv
// Command, seconds-counter and status bundle for stopwatch_controller.
// The controller takes the slave view; whoever drives the commands takes the master view.
interface stopwatch_controller_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic       lap;
  logic [5:0] sec_in;
  logic       sec_rollover;
  logic       sec_enable;
  logic       cnt_rst_n;
  logic [5:0] minutes;
  logic       min_rollover;
  logic [1:0] state;
  logic       running;
  logic       lap_valid;
  logic [5:0] lap_min;
  logic [5:0] lap_sec;

  modport master (
    output start, stop, clear, lap, sec_in, sec_rollover,
    input  sec_enable, cnt_rst_n, minutes, min_rollover, state, running,
           lap_valid, lap_min, lap_sec
  );

  modport slave (
    input  start, stop, clear, lap, sec_in, sec_rollover,
    output sec_enable, cnt_rst_n, minutes, min_rollover, state, running,
           lap_valid, lap_min, lap_sec
  );
endinterface

// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM: one-second prescaler, minute counter and lap capture.
// Lap capture is built only when STOPWATCH_LAP_CAPTURE_EN is defined.
module stopwatch_controller #(
  parameter int TICK_DIV = 100
) (
  input logic                   clk,
  input logic                   rst,
  stopwatch_controller_if.slave bus
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    CLEAR = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_d;
  logic          sec_enable_q, cnt_rst_n_q, running_q;
  logic [5:0]    minutes_q, minutes_d;
  logic          min_rollover_q, min_rollover_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.clear)                  state_d = CLEAR;
        else if (!bus.stop && bus.start) state_d = RUN;
      end
      RUN: begin
        if (bus.clear)     state_d = CLEAR;
        else if (bus.stop) state_d = PAUSE;
      end
      PAUSE: begin
        if (bus.clear)                  state_d = CLEAR;
        else if (!bus.stop && bus.start) state_d = RUN;
      end
      CLEAR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A stop/clear landing on the terminal count swallows the tick and holds the count.
  always_comb begin
    presc_d = '0;
    tick_d  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (presc_q == PRESC_MAX) begin
          if (!bus.stop && !bus.clear) begin
            presc_d = '0;
            tick_d  = 1'b1;
          end else begin
            presc_d = presc_q;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      PAUSE:   presc_d = presc_q;
      default: presc_d = '0;
    endcase
  end

  always_comb begin
    minutes_d      = minutes_q;
    min_rollover_d = 1'b0;
    if (state_q == CLEAR) begin
      minutes_d = '0;
    end else if (bus.sec_rollover) begin
      if (minutes_q >= 6'd59) begin
        minutes_d      = '0;
        min_rollover_d = 1'b1;
      end else begin
        minutes_d = minutes_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      presc_q        <= '0;
      sec_enable_q   <= 1'b0;
      cnt_rst_n_q    <= 1'b0;
      running_q      <= 1'b0;
      minutes_q      <= '0;
      min_rollover_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      sec_enable_q   <= tick_d;
      cnt_rst_n_q    <= (state_d != CLEAR);
      running_q      <= (state_d == RUN);
      minutes_q      <= minutes_d;
      min_rollover_q <= min_rollover_d;
    end
  end

`ifdef STOPWATCH_LAP_CAPTURE_EN
  logic       lap_valid_q;
  logic [5:0] lap_min_q, lap_sec_q;

  always_ff @(posedge clk) begin
    if (rst || state_q == CLEAR) begin
      lap_valid_q <= 1'b0;
      lap_min_q   <= '0;
      lap_sec_q   <= '0;
    end else if (bus.lap && !bus.clear && (state_q == RUN || state_q == PAUSE)) begin
      lap_valid_q <= 1'b1;
      lap_min_q   <= minutes_q;
      lap_sec_q   <= bus.sec_in;
    end
  end

  assign bus.lap_valid = lap_valid_q;
  assign bus.lap_min   = lap_min_q;
  assign bus.lap_sec   = lap_sec_q;
`else
  logic unused_lap_inputs;
  assign unused_lap_inputs = ^{bus.lap, bus.sec_in};

  assign bus.lap_valid = 1'b0;
  assign bus.lap_min   = '0;
  assign bus.lap_sec   = '0;
`endif

  assign bus.state        = state_q;
  assign bus.running      = running_q;
  assign bus.sec_enable   = sec_enable_q;
  assign bus.cnt_rst_n    = cnt_rst_n_q;
  assign bus.minutes      = minutes_q;
  assign bus.min_rollover = min_rollover_q;
endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller with TICK_DIV=4; expectations hand-derived.
module tb_stopwatch_controller;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

`ifdef STOPWATCH_LAP_CAPTURE_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  stopwatch_controller_if bus ();

  stopwatch_controller #(.TICK_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.clear = 1'b0;
    bus.lap = 1'b0;
    bus.sec_in = 6'd0;
    bus.sec_rollover = 1'b0;
    step();
    step();

    chk("rst_state", bus.state, 0);
    chk("rst_sec_enable", bus.sec_enable, 0);
    chk("rst_cnt_rst_n", bus.cnt_rst_n, 0);
    chk("rst_minutes", bus.minutes, 0);
    chk("rst_min_rollover", bus.min_rollover, 0);
    chk("rst_running", bus.running, 0);
    chk("rst_lap_valid", bus.lap_valid, 0);
    chk("rst_lap_min", bus.lap_min, 0);
    chk("rst_lap_sec", bus.lap_sec, 0);

    rst = 1'b0;
    step();
    chk("post_rst_cnt_rst_n", bus.cnt_rst_n, 1);
    chk("post_rst_state", bus.state, 0);

    // stop in IDLE is ignored
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("idle_stop_ignored", bus.state, 0);

    // start in cycle 0: RUN in cycle 1, ticks in 5, 9, 13
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("run_state", bus.state, 1);
    chk("run_running", bus.running, 1);
    chk("run_sec_enable_c1", bus.sec_enable, 0);
    for (int c = 2; c <= 13; c++) begin
      step();
      chk($sformatf("run_tick_c%0d", c), bus.sec_enable, (c == 5 || c == 9 || c == 13) ? 1 : 0);
    end

    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("clear_state", bus.state, 3);
    chk("clear_cnt_rst_n", bus.cnt_rst_n, 0);
    step();
    chk("after_clear_state", bus.state, 0);
    chk("after_clear_cnt_rst_n", bus.cnt_rst_n, 1);

    // RUN cycles 1,2 (stop in 2), pause 10 cycles, resume: tick 2 cycles after RUN returns
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("pause_state", bus.state, 2);
    chk("pause_running", bus.running, 0);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("pause_quiet_%0d", c), bus.sec_enable, 0);
      step();
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("resume_state", bus.state, 1);
    chk("resume_tick_r0", bus.sec_enable, 0);
    step();
    chk("resume_tick_r1", bus.sec_enable, 0);
    step();
    chk("resume_tick_r2", bus.sec_enable, 1);

    // stop on terminal count suppresses the tick and holds at TICK_DIV-1
    step();
    step();
    step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("stop_at_max_state", bus.state, 2);
    chk("stop_at_max_no_tick", bus.sec_enable, 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("held_max_r0", bus.sec_enable, 0);
    step();
    chk("held_max_r1", bus.sec_enable, 1);

    // lap capture while running with minutes=3
    bus.sec_rollover = 1'b1;
    repeat (3) step();
    bus.sec_rollover = 1'b0;
    chk("minutes_3", bus.minutes, 3);
    bus.sec_in = 6'd17;
    bus.lap = 1'b1;
    step();
    bus.lap = 1'b0;
    chk("lap_min", bus.lap_min, LAP_EN ? 3 : 0);
    chk("lap_sec", bus.lap_sec, LAP_EN ? 17 : 0);
    chk("lap_valid", bus.lap_valid, LAP_EN ? 1 : 0);
    bus.sec_in = 6'd9;
    step();
    chk("lap_sticky_sec", bus.lap_sec, LAP_EN ? 17 : 0);
    chk("lap_sticky_valid", bus.lap_valid, LAP_EN ? 1 : 0);

    // start+stop+clear together in RUN
    bus.start = 1'b1;
    bus.stop = 1'b1;
    bus.clear = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.clear = 1'b0;
    chk("multi_cmd_state", bus.state, 3);
    chk("multi_cmd_cnt_rst_n", bus.cnt_rst_n, 0);
    chk("multi_cmd_running", bus.running, 0);
    step();
    chk("multi_cmd_idle", bus.state, 0);
    chk("multi_cmd_minutes", bus.minutes, 0);
    chk("multi_cmd_cnt_rst_n_hi", bus.cnt_rst_n, 1);
    chk("multi_cmd_lap_valid", bus.lap_valid, 0);
    chk("multi_cmd_lap_min", bus.lap_min, 0);

    bus.lap = 1'b1;
    bus.sec_in = 6'd5;
    step();
    bus.lap = 1'b0;
    chk("idle_lap_ignored", bus.lap_valid, 0);

    // minute wrap 59 -> 0
    bus.sec_rollover = 1'b1;
    repeat (59) step();
    bus.sec_rollover = 1'b0;
    chk("minutes_59", bus.minutes, 59);
    chk("no_rollover_at_59", bus.min_rollover, 0);
    bus.sec_rollover = 1'b1;
    step();
    bus.sec_rollover = 1'b0;
    chk("wrap_minutes", bus.minutes, 0);
    chk("wrap_min_rollover", bus.min_rollover, 1);
    step();
    chk("wrap_min_rollover_drop", bus.min_rollover, 0);
    chk("wrap_minutes_hold", bus.minutes, 0);

    // CLEAR beats a rollover arriving while in CLEAR
    bus.clear = 1'b1;
    bus.sec_rollover = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("clear_cmd_rollover_counted", bus.minutes, 1);
    step();
    bus.sec_rollover = 1'b0;
    chk("clear_beats_rollover", bus.minutes, 0);
    chk("clear_beats_rollover_state", bus.state, 0);

    // rst mid-RUN with prescaler at 2
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.lap = 1'b1;
    bus.sec_in = 6'd33;
    step();
    bus.lap = 1'b0;
    step();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.sec_rollover = 1'b1;
    step();
    rst = 1'b0;
    bus.start = 1'b0;
    bus.sec_rollover = 1'b0;
    chk("mid_run_rst_state", bus.state, 0);
    chk("mid_run_rst_running", bus.running, 0);
    chk("mid_run_rst_sec_enable", bus.sec_enable, 0);
    chk("mid_run_rst_cnt_rst_n", bus.cnt_rst_n, 0);
    chk("mid_run_rst_minutes", bus.minutes, 0);
    chk("mid_run_rst_lap_valid", bus.lap_valid, 0);
    chk("mid_run_rst_lap_sec", bus.lap_sec, 0);
    step();
    chk("mid_run_rst_release", bus.cnt_rst_n, 1);
    chk("mid_run_rst_idle", bus.state, 0);
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("post_rst_quiet_%0d", c), bus.sec_enable, 0);
    end

    // rst during CLEAR
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("clear_rst_state", bus.state, 0);
    chk("clear_rst_cnt_rst_n", bus.cnt_rst_n, 0);
    step();
    chk("clear_rst_release", bus.cnt_rst_n, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
